cpu_core: RTL

- Parametrised successor to the first-generation 6502-style CPU: same single-master bus (address/read/write strobes, data_valid_i stall) and clock-enable-paced execution.
- Adds a configurable reset vector and stack page, memory writes (STA zp, PHA), stack pull (PLA), SBC, and a true V flag.
- Sits between the system bus fabric and the top level. All state advances only on internal clock-enable pulses.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/cpu_alu.sv | 30 +++
 rtl/cpu_core.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502-style core: opcodes, status bit positions,
// execution stages and architectural reset values.
package cpu_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_SBC_IMM = 8'hE9;
    localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_PHA     = 8'h48;
    localparam logic [7:0] OP_PLA     = 8'h68;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    localparam int STATUS_C = 0;
    localparam int STATUS_Z = 1;
    localparam int STATUS_I = 2;
    localparam int STATUS_D = 3;
    localparam int STATUS_B = 4;
    localparam int STATUS_V = 6;
    localparam int STATUS_N = 7;

    localparam logic [7:0] SP_RESET = 8'hFD;
    localparam logic [7:0] P_RESET  = 8'h34;

    typedef enum logic [2:0] {
        RST_LO,
        RST_HI,
        FETCH,
        EX1,
        EX2
    } stage_t;

    function automatic logic [7:0] with_nz(input logic [7:0] p, input logic [7:0] value);
        logic [7:0] r;
        r = p;
        r[STATUS_N] = value[7];
        r[STATUS_Z] = (value == 8'h00);
        return r;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational adder for ADC/SBC; SBC is ADC with the operand inverted.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] m,
    input  logic       carry_in,
    input  logic       subtract,
    output logic [7:0] result,
    output logic       c,
    output logic       v,
    output logic       n,
    output logic       z
);

    logic [7:0] m_eff;
    logic [8:0] sum;

    always_comb begin
        m_eff  = subtract ? ~m : m;
        sum    = {1'b0, a} + {1'b0, m_eff} + {8'h00, carry_in};
        result = sum[7:0];
        c      = sum[8];
        // Overflow: both addends share a sign that the result does not.
        v      = (a[7] == m_eff[7]) && (sum[7] != a[7]);
        n      = sum[7];
        z      = (sum[7:0] == 8'h00);
    end

endmodule

// File: rtl/cpu_core.sv
// Clock-enable paced 6502-style core with a single-master read/write bus;
// a read stage stalls while data_valid_i is low, a write stage never does.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int          CLOCK_DIVIDER = 12,
    parameter logic [15:0] RESET_VECTOR  = 16'hFFFC,
    parameter logic [7:0]  STACK_PAGE    = 8'h01
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic [7:0]  data_o,
    output logic [15:0] address_o,
    output logic        bus_read_o,
    output logic        bus_write_o,
    output logic        clock_ready_o,
    output logic [15:0] program_counter_o,
    output logic [7:0]  accumulator_o,
    output logic [7:0]  index_x_o,
    output logic [7:0]  index_y_o,
    output logic [7:0]  status_o,
    output logic [7:0]  stack_pointer_o
);

    localparam int DIV_W = $clog2(CLOCK_DIVIDER);

    logic [DIV_W-1:0] div_count;
    logic             ce, advance, needs_valid, known_op;
    stage_t           stage, stage_n;
    logic [15:0]      pc, pc_n, addr, addr_n;
    logic [7:0]       a, a_n, x, x_n, y, y_n, sp, sp_n, p, p_n, ir, ir_n, hold, hold_n;
    logic [7:0]       dout, dout_n, sp_inc;
    logic             rd, rd_n, wr, wr_n;
    logic [7:0]       alu_result;
    logic             alu_c, alu_v, alu_n, alu_z;

    cpu_alu u_alu (
        .a        (a),
        .m        (data_i),
        .carry_in (p[STATUS_C]),
        .subtract (ir == OP_SBC_IMM),
        .result   (alu_result),
        .c        (alu_c),
        .v        (alu_v),
        .n        (alu_n),
        .z        (alu_z)
    );

    assign ce = (div_count == DIV_W'(CLOCK_DIVIDER - 1));
    assign known_op = ir inside {OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_ADC_IMM, OP_SBC_IMM,
                                 OP_LDA_ZP, OP_STA_ZP, OP_PHA, OP_PLA, OP_JMP_ABS};
    // Unknown opcodes (NOP included) spend EX1 as a dummy cycle that never waits on the bus.
    assign needs_valid = rd && !(stage == EX1 && !known_op);
    assign advance     = ce && (!needs_valid || data_valid_i);
    assign sp_inc      = sp + 8'd1;

    always_comb begin
        stage_n = stage;
        pc_n    = pc;
        addr_n  = addr;
        a_n     = a;
        x_n     = x;
        y_n     = y;
        sp_n    = sp;
        p_n     = p;
        ir_n    = ir;
        hold_n  = hold;
        dout_n  = dout;
        rd_n    = rd;
        wr_n    = wr;
        case (stage)
            RST_LO: begin
                pc_n    = {pc[15:8], data_i};
                addr_n  = RESET_VECTOR + 16'd1;
                stage_n = RST_HI;
            end
            RST_HI: begin
                pc_n    = {data_i, pc[7:0]};
                addr_n  = {data_i, pc[7:0]};
                stage_n = FETCH;
            end
            FETCH: begin
                ir_n    = data_i;
                pc_n    = pc + 16'd1;
                addr_n  = pc + 16'd1;
                stage_n = EX1;
            end
            EX1: begin
                stage_n = FETCH;
                case (ir)
                    OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: begin
                        if (ir == OP_LDA_IMM) a_n = data_i;
                        if (ir == OP_LDX_IMM) x_n = data_i;
                        if (ir == OP_LDY_IMM) y_n = data_i;
                        p_n    = with_nz(p, data_i);
                        pc_n   = pc + 16'd1;
                        addr_n = pc + 16'd1;
                    end
                    OP_ADC_IMM, OP_SBC_IMM: begin
                        a_n           = alu_result;
                        p_n[STATUS_C] = alu_c;
                        p_n[STATUS_V] = alu_v;
                        p_n[STATUS_N] = alu_n;
                        p_n[STATUS_Z] = alu_z;
                        pc_n          = pc + 16'd1;
                        addr_n        = pc + 16'd1;
                    end
                    OP_LDA_ZP: begin
                        addr_n  = {8'h00, data_i};
                        pc_n    = pc + 16'd1;
                        stage_n = EX2;
                    end
                    OP_STA_ZP: begin
                        addr_n  = {8'h00, data_i};
                        rd_n    = 1'b0;
                        wr_n    = 1'b1;
                        dout_n  = a;
                        pc_n    = pc + 16'd1;
                        stage_n = EX2;
                    end
                    OP_PHA: begin
                        addr_n  = {STACK_PAGE, sp};
                        rd_n    = 1'b0;
                        wr_n    = 1'b1;
                        dout_n  = a;
                        sp_n    = sp - 8'd1;
                        stage_n = EX2;
                    end
                    OP_PLA: begin
                        sp_n    = sp_inc;
                        addr_n  = {STACK_PAGE, sp_inc};
                        stage_n = EX2;
                    end
                    OP_JMP_ABS: begin
                        hold_n  = data_i;
                        pc_n    = pc + 16'd1;
                        addr_n  = pc + 16'd1;
                        stage_n = EX2;
                    end
                    default: ;
                endcase
            end
            EX2: begin
                stage_n = FETCH;
                addr_n  = pc;
                rd_n    = 1'b1;
                wr_n    = 1'b0;
                if (ir == OP_LDA_ZP || ir == OP_PLA) begin
                    a_n = data_i;
                    p_n = with_nz(p, data_i);
                end
                if (ir == OP_JMP_ABS) begin
                    pc_n   = {data_i, hold};
                    addr_n = {data_i, hold};
                end
            end
            default: stage_n = RST_LO;
        endcase
        p_n[5] = 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_count <= '0;
            stage     <= RST_LO;
            pc        <= 16'h0000;
            addr      <= RESET_VECTOR;
            a         <= 8'h00;
            x         <= 8'h00;
            y         <= 8'h00;
            sp        <= SP_RESET;
            p         <= P_RESET;
            ir        <= 8'h00;
            hold      <= 8'h00;
            dout      <= 8'h00;
            rd        <= 1'b1;
            wr        <= 1'b0;
        end else begin
            div_count <= ce ? '0 : div_count + DIV_W'(1);
            if (advance) begin
                stage <= stage_n;
                pc    <= pc_n;
                addr  <= addr_n;
                a     <= a_n;
                x     <= x_n;
                y     <= y_n;
                sp    <= sp_n;
                p     <= p_n;
                ir    <= ir_n;
                hold  <= hold_n;
                dout  <= dout_n;
                rd    <= rd_n;
                wr    <= wr_n;
            end
        end
    end

    assign data_o            = dout;
    assign address_o         = addr;
    assign bus_read_o        = rd;
    assign bus_write_o       = wr;
    assign clock_ready_o     = ce;
    assign program_counter_o = pc;
    assign accumulator_o     = a;
    assign index_x_o         = x;
    assign index_y_o         = y;
    assign status_o          = p;
    assign stack_pointer_o   = sp;

endmodule
